// File: rtl/issue_arbiter_pkg.sv
// issue_arbiter_pkg: CDB owner codes, default unit latencies and shared helpers
// for the issue arbiter and its CDB slot reservation schedule.
package issue_arbiter_pkg;

    localparam logic [1:0] CDB_SRC_INT  = 2'b00;
    localparam logic [1:0] CDB_SRC_LDST = 2'b01;
    localparam logic [1:0] CDB_SRC_MUL  = 2'b10;
    localparam logic [1:0] CDB_SRC_DIV  = 2'b11;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 7;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hffff) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/issue_arbiter_slot.sv
// cdb_slot_reserve: shift-register schedule of future CDB claims (resv/owner),
// with set ports for mul/div grants and queries for slot now+1 and now+MUL_LAT.
module cdb_slot_reserve
    import issue_arbiter_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_mul,
    input  logic       set_div,
    output logic       mul_slot_busy,
    output logic       slot1_valid,
    output logic [1:0] slot1_owner
);

    logic [DIV_LAT-1:1]       resv_q, resv_d;
    logic [DIV_LAT-1:1][1:0]  owner_q, owner_d;

    // Slots advance one step toward "now" every cycle; new claims enter at their latency.
    always_comb begin
        resv_d  = {1'b0, resv_q[DIV_LAT-1:2]};
        owner_d = {CDB_SRC_INT, owner_q[DIV_LAT-1:2]};
        if (set_mul) begin
            resv_d[MUL_LAT-1]  = 1'b1;
            owner_d[MUL_LAT-1] = CDB_SRC_MUL;
        end
        if (set_div) begin
            resv_d[DIV_LAT-1]  = 1'b1;
            owner_d[DIV_LAT-1] = CDB_SRC_DIV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_q  <= '0;
            owner_q <= '0;
        end else begin
            resv_q  <= resv_d;
            owner_q <= owner_d;
        end
    end

    assign mul_slot_busy = resv_q[MUL_LAT];
    assign slot1_valid   = resv_q[1];
    assign slot1_owner   = owner_q[1];

endmodule

// File: rtl/issue_arbiter.sv
// issue_arbiter: per-cycle issue grants for int/ld_st/mul/div queues and registered CDB select.
// Optional ISSUE_ARB_PERF_EN adds saturating grant and slot-stall counters.
module issue_arbiter
    import issue_arbiter_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issueque_ready_int,
    input  logic        issueque_ready_ld_st,
    input  logic        issueque_ready_mul,
    input  logic        issueque_ready_div,
    output logic        issue_int,
    output logic        issue_ld_st,
    output logic        issue_mul,
    output logic        issue_div,
    output logic [1:0]  cdb_sel,
    output logic        cdb_sel_valid,
    output logic        div_busy
`ifdef ISSUE_ARB_PERF_EN
    ,
    output logic [15:0] perf_grant_int,
    output logic [15:0] perf_grant_ld_st,
    output logic [15:0] perf_grant_mul,
    output logic [15:0] perf_grant_div,
    output logic [15:0] perf_slot_stall
`endif
);

    localparam int CW = $clog2(DIV_LAT);

    logic          lru_q, lru_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    cdb_sel_q, cdb_sel_d;
    logic          cdb_sel_valid_q, cdb_sel_valid_d;
    logic          mul_slot_busy, slot1_valid;
    logic [1:0]    slot1_owner;

    cdb_slot_reserve #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_mul      (issue_mul),
        .set_div      (issue_div),
        .mul_slot_busy(mul_slot_busy),
        .slot1_valid  (slot1_valid),
        .slot1_owner  (slot1_owner)
    );

    // Grants are held low during reset even though the requests may be high.
    assign issue_int   = rst_n & issueque_ready_int & (~issueque_ready_ld_st | ~lru_q);
    assign issue_ld_st = rst_n & issueque_ready_ld_st & (~issueque_ready_int | lru_q);
    assign issue_mul   = rst_n & issueque_ready_mul & ~mul_slot_busy;
    assign issue_div   = rst_n & issueque_ready_div & (div_cnt_q == '0);

    always_comb begin
        cdb_sel_d       = issue_int ? CDB_SRC_INT : issue_ld_st ? CDB_SRC_LDST : slot1_owner;
        cdb_sel_valid_d = issue_int | issue_ld_st | slot1_valid;
        lru_d           = issue_int ? 1'b1 : issue_ld_st ? 1'b0 : lru_q;
        div_cnt_d       = issue_div ? CW'(DIV_LAT - 1) : (div_cnt_q != '0) ? div_cnt_q - 1'b1 : div_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q           <= 1'b0;
            div_cnt_q       <= '0;
            cdb_sel_q       <= CDB_SRC_INT;
            cdb_sel_valid_q <= 1'b0;
        end else begin
            lru_q           <= lru_d;
            div_cnt_q       <= div_cnt_d;
            cdb_sel_q       <= cdb_sel_d;
            cdb_sel_valid_q <= cdb_sel_valid_d;
        end
    end

    assign cdb_sel       = cdb_sel_q;
    assign cdb_sel_valid = cdb_sel_valid_q;
    assign div_busy      = (div_cnt_q != '0);

`ifdef ISSUE_ARB_PERF_EN
    logic [15:0] perf_int_q, perf_int_d, perf_ldst_q, perf_ldst_d;
    logic [15:0] perf_mul_q, perf_mul_d, perf_div_q, perf_div_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    // The div slot at now+DIV_LAT is never reserved, so only mul can stall on resv.
    always_comb begin
        perf_int_d   = sat_inc(perf_int_q, issue_int);
        perf_ldst_d  = sat_inc(perf_ldst_q, issue_ld_st);
        perf_mul_d   = sat_inc(perf_mul_q, issue_mul);
        perf_div_d   = sat_inc(perf_div_q, issue_div);
        perf_stall_d = sat_inc(perf_stall_q, issueque_ready_mul & mul_slot_busy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_int_q   <= '0;
            perf_ldst_q  <= '0;
            perf_mul_q   <= '0;
            perf_div_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_int_q   <= perf_int_d;
            perf_ldst_q  <= perf_ldst_d;
            perf_mul_q   <= perf_mul_d;
            perf_div_q   <= perf_div_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_int   = perf_int_q;
    assign perf_grant_ld_st = perf_ldst_q;
    assign perf_grant_mul   = perf_mul_q;
    assign perf_grant_div   = perf_div_q;
    assign perf_slot_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_arbiter.sv
// tb_issue_arbiter: directed and random issue requests checked against a
// cycle-indexed model of grants and CDB claims.
module tb_issue_arbiter;

    localparam int ML = 4;
    localparam int DL = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ri = 1'b0, rl = 1'b0, rm = 1'b0, rd = 1'b0;
    logic       g_int, g_ldst, g_mul, g_div;
    logic [1:0] cdb_sel;
    logic       cdb_sel_valid, div_busy;
`ifdef ISSUE_ARB_PERF_EN
    logic [15:0] p_int, p_ldst, p_mul, p_div, p_stall;
`endif

    issue_arbiter #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .issueque_ready_int  (ri),
        .issueque_ready_ld_st(rl),
        .issueque_ready_mul  (rm),
        .issueque_ready_div  (rd),
        .issue_int           (g_int),
        .issue_ld_st         (g_ldst),
        .issue_mul           (g_mul),
        .issue_div           (g_div),
        .cdb_sel             (cdb_sel),
        .cdb_sel_valid       (cdb_sel_valid),
        .div_busy            (div_busy)
`ifdef ISSUE_ARB_PERF_EN
        ,
        .perf_grant_int      (p_int),
        .perf_grant_ld_st    (p_ldst),
        .perf_grant_mul      (p_mul),
        .perf_grant_div      (p_div),
        .perf_slot_stall     (p_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: absolute cycle numbers mapped to the unit whose result is on the CDB then.
    int cyc = 0;
    int claim[int];
    int lat1_at[int];
    bit lru = 0;
    int div_next = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit a, input bit b, input bit c, input bit d);
        bit exp_v, gi, gl, gm, gd;
        int exp_s;
        @(negedge clk);
        ri = a; rl = b; rm = c; rd = d;
        #1;
        exp_v = lat1_at.exists(cyc) || claim.exists(cyc);
        exp_s = lat1_at.exists(cyc) ? lat1_at[cyc] : claim.exists(cyc) ? claim[cyc] : 0;
        check("cdb_valid", 32'(cdb_sel_valid), 32'(exp_v));
        if (exp_v) check("cdb_sel", 32'(cdb_sel), 32'(exp_s));
        gi = a && (!b || !lru);
        gl = b && (!a || lru);
        gm = c && !claim.exists(cyc + ML);
        gd = d && cyc >= div_next && !claim.exists(cyc + DL);
        check("issue_int", 32'(g_int), 32'(gi));
        check("issue_ld_st", 32'(g_ldst), 32'(gl));
        check("issue_mul", 32'(g_mul), 32'(gm));
        check("issue_div", 32'(g_div), 32'(gd));
        check("div_busy", 32'(div_busy), 32'(cyc < div_next));
        if (gi) begin lat1_at[cyc + 1] = 0; lru = 1; end
        if (gl) begin lat1_at[cyc + 1] = 1; lru = 0; end
        if (gm) claim[cyc + ML] = 2;
        if (gd) begin claim[cyc + DL] = 3; div_next = cyc + DL; end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ri = 1'b1; rl = 1'b1; rm = 1'b1; rd = 1'b1;
        #1;
        check("rst_grants", 32'({g_int, g_ldst, g_mul, g_div}), 32'd0);
        check("rst_cdb_valid", 32'(cdb_sel_valid), 32'd0);
        check("rst_cdb_sel", 32'(cdb_sel), 32'd0);
        check("rst_div_busy", 32'(div_busy), 32'd0);
        @(negedge clk);
        #1;
        check("rst_hold_grants", 32'({g_int, g_ldst, g_mul, g_div}), 32'd0);
        ri = 1'b0; rl = 1'b0; rm = 1'b0; rd = 1'b0;
        rst_n = 1'b1;
        claim.delete();
        lat1_at.delete();
        lru = 0;
        div_next = 0;
        cyc += 2;
    endtask

    initial begin
        do_reset();
        repeat (4) step(1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        repeat (16) step(0, 0, 0, 1);
        repeat (8) step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        repeat (8) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        do_reset();
        repeat (10) step(0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
